// File: rtl/rf_wb_sched_if.sv
// Writeback request bundle: three sources, each with valid/ready/addr/data.
// The master side is the execution units; the slave side is the scheduler.
interface rf_wb_sched_if #(
  parameter int DATA_W = 32
);
  logic              wb0_valid;
  logic              wb0_ready;
  logic [4:0]        wb0_addr;
  logic [DATA_W-1:0] wb0_data;
  logic              wb1_valid;
  logic              wb1_ready;
  logic [4:0]        wb1_addr;
  logic [DATA_W-1:0] wb1_data;
  logic              wb2_valid;
  logic              wb2_ready;
  logic [4:0]        wb2_addr;
  logic [DATA_W-1:0] wb2_data;

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    output wb2_valid, wb2_addr, wb2_data,
    input  wb0_ready, wb1_ready, wb2_ready
  );

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    input  wb2_valid, wb2_addr, wb2_data,
    output wb0_ready, wb1_ready, wb2_ready
  );
endinterface

// File: rtl/rf_wb_sched.sv
// Register-file writeback arbiter with a pending-write scoreboard for decode hazards.
// Define RF_WB_RR_EN for round-robin arbitration; default build uses fixed priority wb0 > wb1 > wb2.
module rf_wb_sched #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  rf_wb_sched_if.slave      wb,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_addr,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic              hazard,
  output logic [31:0]       busy,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  logic [2:0]        req;
  logic [2:0]        gnt_raw;
  logic [2:0]        gnt;
  logic              any_gnt;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       busy_nxt;

  logic              vld_p1;
  logic [4:0]        waddr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [31:0]       busy_p1;

  assign req = {wb.wb2_valid, wb.wb1_valid, wb.wb0_valid};

`ifdef RF_WB_RR_EN
  // ptr_p0 names the source holding highest priority this cycle.
  logic [1:0] ptr_p0;

  always_comb begin
    gnt_raw = 3'b000;
    case (ptr_p0)
      2'd0:    gnt_raw = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
      2'd1:    gnt_raw = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      default: gnt_raw = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_p0 <= 2'd0;
    end else if (gnt[0]) begin
      ptr_p0 <= 2'd1;
    end else if (gnt[1]) begin
      ptr_p0 <= 2'd2;
    end else if (gnt[2]) begin
      ptr_p0 <= 2'd0;
    end
  end
`else
  always_comb begin
    gnt_raw = 3'b000;
    if (req[0])      gnt_raw = 3'b001;
    else if (req[1]) gnt_raw = 3'b010;
    else if (req[2]) gnt_raw = 3'b100;
  end
`endif

  assign gnt          = reset ? 3'b000 : gnt_raw;
  assign any_gnt      = |gnt;
  assign wb.wb0_ready = gnt[0];
  assign wb.wb1_ready = gnt[1];
  assign wb.wb2_ready = gnt[2];

  always_comb begin
    sel_addr = 5'd0;
    sel_data = '0;
    if (gnt[0]) begin
      sel_addr = wb.wb0_addr;
      sel_data = wb.wb0_data;
    end else if (gnt[1]) begin
      sel_addr = wb.wb1_addr;
      sel_data = wb.wb1_data;
    end else if (gnt[2]) begin
      sel_addr = wb.wb2_addr;
      sel_data = wb.wb2_data;
    end
  end

  // Clear is applied before set so a same-edge alloc of the retiring register keeps it pending.
  always_comb begin
    busy_nxt = busy_p1;
    if (any_gnt)     busy_nxt[sel_addr]   = 1'b0;
    if (alloc_valid) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // p0 -> p1: grant registered onto the register-file write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= 5'd0;
      wdata_p1 <= '0;
      busy_p1  <= 32'd0;
    end else begin
      vld_p1  <= any_gnt && (sel_addr != 5'd0);
      busy_p1 <= busy_nxt;
      if (any_gnt) begin
        waddr_p1 <= sel_addr;
        wdata_p1 <= sel_data;
      end
    end
  end

  assign rf_we    = vld_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;
  assign busy     = busy_p1;
  assign hazard   = ((rs1_addr != 5'd0) && busy_p1[rs1_addr]) ||
                    ((rs2_addr != 5'd0) && busy_p1[rs2_addr]);

endmodule

// File: doc/rf_wb_sched.md
RF_WB_SCHED -- requirements
Module: rf_wb_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports wbN_valid  input  1  writeback request from source N, for N=0,1,2.
REQ-004 SHALL have ports wbN_ready  output  1  grant to source N, combinational; transfer when valid&ready.
REQ-005 SHALL have ports wbN_addr  input  5  destination register of source N.
REQ-006 SHALL have ports wbN_data  input  32  write data of source N.
REQ-007 SHALL have port: alloc_valid  input  1  decode issued an instruction writing alloc_addr.
REQ-008 SHALL have port: alloc_addr  input  5  destination register being allocated.
REQ-009 SHALL have ports rs1_addr, rs2_addr  input  5 each  source registers of the instruction in decode.
REQ-010 SHALL have port: hazard  output  1  combinational; decode must stall while 1.
REQ-011 SHALL have port: busy  output  32  per-register pending-write scoreboard.
REQ-012 SHALL have ports rf_we  output  1, rf_waddr  output  5, rf_wdata  output  32  registered register-file write port.

Function
REQ-013 SHALL grant at most one wbN_ready per cycle, and only to a source with wbN_valid=1.
REQ-014 SHALL drive wbN_ready=0 for every source whose valid is 0; ready SHALL NOT depend on ready of any other block.
REQ-015 SHALL, without RF_WB_RR_EN, use fixed priority wb0 > wb1 > wb2.
REQ-016 SHALL register a granted transfer: edge after grant, rf_we=1, rf_waddr=wbN_addr, rf_wdata=wbN_data (latency 1).
REQ-017 SHALL drive rf_we=0 in any cycle following a cycle with no grant; rf_waddr/rf_wdata hold last value.
REQ-018 SHALL accept a granted transfer with wbN_addr=0 but drive rf_we=0 for it (write discarded).
REQ-019 SHALL set busy[alloc_addr] at the edge where alloc_valid=1 and alloc_addr!=0.
REQ-020 SHALL clear busy[wbN_addr] at the edge where the grant of that transfer is registered (same edge rf_we rises).
REQ-021 SHALL, on alloc and clear of the same register at the same edge, leave the bit set (set wins).
REQ-022 SHALL keep busy[0]=0 at all times.
REQ-023 SHALL keep a bit at 1 if alloc targets an already-busy register; first writeback clears it.
REQ-024 SHALL compute hazard = (rs1_addr!=0 & busy[rs1_addr]) | (rs2_addr!=0 & busy[rs2_addr]).
REQ-025 SHALL rely on the register file's same-address write bypass in the rf_we cycle; no extra forwarding here.

Reset
REQ-026 SHALL, while reset=1, immediately force rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, round-robin pointer=0.
REQ-027 SHALL drop any in-flight grant on reset assertion; no write is issued after reset releases.
REQ-028 SHALL drive all wbN_ready=0 while reset=1.
REQ-029 SHALL resume normal arbitration on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL, with macro RF_WB_RR_EN defined, arbitrate round-robin: priority starts at source after last granted; pointer reset selects wb0 first.
REQ-031 SHALL, without RF_WB_RR_EN, use REQ-015 fixed priority with no pointer state.
REQ-032 SHALL keep all other behaviour and ports identical in both builds.

Verification
REQ-033 SHALL cover: wb0,wb1 valid together, wb0_addr=5, data 0x11 -> wb0_ready=1, next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11.
REQ-034 SHALL cover: alloc r7; rs1_addr=7 -> hazard=1 until wb2 write r7 granted; hazard=0 on the edge rf_we=1.
REQ-035 SHALL cover: granted write to r0 with data 0xFFFF_FFFF -> rf_we stays 0, busy[0]=0.
REQ-036 SHALL cover: alloc r3 same edge as writeback of r3 registers -> busy[3]=1 afterwards.
REQ-037 SHALL cover (RF_WB_RR_EN): all three valid for 6 cycles -> grant order 0,1,2,0,1,2; without macro -> 0 each cycle.
REQ-038 SHALL cover: reset asserted mid-cycle after grant -> rf_we=0 immediately, busy=0, no write after release.
